checkpoint_rollback: RTL



---
 rtl/ft_pkg.sv | 20 ++
 rtl/ckpt_bank_ram.sv | 61 ++++++
 rtl/checkpoint_rollback.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ft_pkg.sv
// Shared fault-tolerance definitions: checkpoint_rollback state
// encoding, datapath defaults and recovery handshake widths.
package ft_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

  // Recovery FSM handshake lines (freeze/recover/resume/done).
  localparam int FSM_HS_W = 1;

  typedef enum logic [2:0] {
    CR_IDLE     = 3'd0,
    CR_SNAPSHOT = 3'd1,
    CR_RESTORE  = 3'd2,
    CR_PC_LOAD  = 3'd3,
    CR_WAIT_REL = 3'd4
  } cr_state_e;

endpackage

// File: rtl/ckpt_bank_ram.sv
// Double-buffered shadow store: two banks of x1..x(NUM_REGS-1) plus a
// PC word per bank. One write port, one async read port.
// Ports:
//   clk            clock
//   wr_en_i        register write strobe
//   wr_bank_i      bank selected for the register write
//   wr_addr_i      architectural register number (1..NUM_REGS-1)
//   wr_data_i      register write data
//   pc_wr_en_i     PC word write strobe
//   pc_wr_bank_i   bank selected for the PC write
//   pc_wr_data_i   PC write data
//   rd_bank_i      bank selected for reads
//   rd_addr_i      architectural register number to read
//   rd_data_o      register read data
//   rd_pc_o        PC word of the read bank
module ckpt_bank_ram
  import ft_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic              wr_bank_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [XLEN-1:0]   wr_data_i,
  input  logic              pc_wr_en_i,
  input  logic              pc_wr_bank_i,
  input  logic [XLEN-1:0]   pc_wr_data_i,
  input  logic              rd_bank_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [XLEN-1:0]   rd_data_o,
  output logic [XLEN-1:0]   rd_pc_o
);

  localparam int DEPTH = NUM_REGS - 1;

  logic [XLEN-1:0] mem_q [2][DEPTH];
  logic [XLEN-1:0] pc_q  [2];

  // x0 is never stored, so register n lives in slot n-1.
  logic [ADDR_W-1:0] wr_slot;
  logic [ADDR_W-1:0] rd_slot;

  assign wr_slot = wr_addr_i - ADDR_W'(1);
  assign rd_slot = rd_addr_i - ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_bank_i][wr_slot] <= wr_data_i;
    end
    if (pc_wr_en_i) begin
      pc_q[pc_wr_bank_i] <= pc_wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_bank_i][rd_slot];
  assign rd_pc_o   = pc_q[rd_bank_i];

endmodule

// File: rtl/checkpoint_rollback.sv
// Checkpoint/rollback engine: snapshots RF+PC into a shadow bank and
// restores the last complete checkpoint when recovery is requested.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   checkpoint_req   snapshot request pulse from commit
//   cur_pc           committed PC, latched on request accept
//   freeze_cpu       recovery FSM freeze (aborts a snapshot)
//   recover_cpu      recovery FSM restore request
//   resume_cpu       recovery FSM resume (no effect here)
//   rf_rd_addr/data  RF read port used while snapshotting
//   rf_wr_en/addr/data  RF restore write port
//   pc_wr_en/data    PC load port
//   recovery_done    one-cycle completion pulse
//   ckpt_busy        snapshot in progress
//   ckpt_valid       a complete checkpoint exists
module checkpoint_rollback
  import ft_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter int              NUM_REGS     = NUM_REGS_DEF,
  parameter int              ADDR_W       = $clog2(NUM_REGS),
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              checkpoint_req,
  input  logic [XLEN-1:0]   cur_pc,
  input  logic              freeze_cpu,
  input  logic              recover_cpu,
  input  logic              resume_cpu,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [XLEN-1:0]   rf_rd_data,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [XLEN-1:0]   rf_wr_data,
  output logic              pc_wr_en,
  output logic [XLEN-1:0]   pc_wr_data,
  output logic              recovery_done,
  output logic              ckpt_busy,
  output logic              ckpt_valid
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

  cr_state_e state_q;

  logic [ADDR_W-1:0] idx_q;
  logic              active_q;
  logic              valid_q;
  logic              busy_q;
  logic              wr_en_q;
  logic              pc_en_q;

  logic              accept;
  logic              abort;
  logic              is_last;
  logic [XLEN-1:0]   bank_rd_data;
  logic [XLEN-1:0]   bank_rd_pc;
  logic              unused_resume;

  assign unused_resume = resume_cpu;

  // Recovery requests take priority over a same-cycle snapshot.
  assign accept = (state_q == CR_IDLE) && checkpoint_req &&
                  !freeze_cpu && !recover_cpu;
  assign abort   = freeze_cpu || recover_cpu;
  assign is_last = (idx_q == LAST_IDX);

  // Snapshots always target the inactive bank so an aborted
  // snapshot leaves the active checkpoint untouched.
  ckpt_bank_ram #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_bank (
    .clk          (clk),
    .wr_en_i      (busy_q),
    .wr_bank_i    (~active_q),
    .wr_addr_i    (idx_q),
    .wr_data_i    (rf_rd_data),
    .pc_wr_en_i   (accept),
    .pc_wr_bank_i (~active_q),
    .pc_wr_data_i (cur_pc),
    .rd_bank_i    (active_q),
    .rd_addr_i    (idx_q),
    .rd_data_o    (bank_rd_data),
    .rd_pc_o      (bank_rd_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CR_IDLE;
      idx_q    <= '0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      wr_en_q  <= 1'b0;
      pc_en_q  <= 1'b0;
    end else begin
      unique case (state_q)
        CR_IDLE: begin
          if (recover_cpu) begin
            state_q <= CR_RESTORE;
            idx_q   <= FIRST_IDX;
            wr_en_q <= 1'b1;
          end else if (accept) begin
            state_q <= CR_SNAPSHOT;
            idx_q   <= FIRST_IDX;
            busy_q  <= 1'b1;
          end
        end
        CR_SNAPSHOT: begin
          if (abort) begin
            state_q <= CR_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end else if (is_last) begin
            state_q  <= CR_IDLE;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            active_q <= ~active_q;
            valid_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        CR_RESTORE: begin
          // Runs to completion even if recover_cpu drops.
          if (is_last) begin
            state_q <= CR_PC_LOAD;
            idx_q   <= '0;
            wr_en_q <= 1'b0;
            pc_en_q <= 1'b1;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        CR_PC_LOAD: begin
          state_q <= CR_WAIT_REL;
          pc_en_q <= 1'b0;
        end
        CR_WAIT_REL: begin
          // Hold off until the FSM releases recover_cpu.
          if (!recover_cpu) begin
            state_q <= CR_IDLE;
          end
        end
        default: begin
          state_q <= CR_IDLE;
          idx_q   <= '0;
          busy_q  <= 1'b0;
          wr_en_q <= 1'b0;
          pc_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign rf_rd_addr = busy_q ? idx_q : '0;

  assign rf_wr_en   = wr_en_q;
  assign rf_wr_addr = wr_en_q ? idx_q : '0;
  assign rf_wr_data = (wr_en_q && valid_q) ? bank_rd_data : '0;

  assign pc_wr_en   = pc_en_q;
  assign pc_wr_data = !pc_en_q ? '0 :
                      valid_q  ? bank_rd_pc : RESET_VECTOR;

  assign recovery_done = pc_en_q;
  assign ckpt_busy     = busy_q;
  assign ckpt_valid    = valid_q;

endmodule
